// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
package seg_pkg;

    localparam int unsigned MAX_DIGITS = 8;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;

    // Active-high glyphs, bit order gfedcba, indexed by nibble value.
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [MAX_DIGITS-1:0] an_onehot_n(input logic [2:0] idx);
        return ~(MAX_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_c_o
);

    assign seg_c_o = ~GLYPH[nib_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with leading-zero
// blanking and a per-slot anode guard window.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned CLK_DIV  = 50000,
    parameter int unsigned GUARD    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*N_DIGITS-1:0]         digits,
    input  logic [N_DIGITS-1:0]           dp_in,
    input  logic                          lz_en,
    input  logic                          en,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [N_DIGITS-1:0]           an,
    output logic [$clog2(N_DIGITS)-1:0]   scan_idx
);

    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;

    logic [3:0] nib_c;
    logic [6:0] glyph_n_c;
    logic       blank_c;
    logic       dp_sel_c;
    logic       zero_above_c;
    logic       in_guard_c;
    logic       tick_c;

    assign tick_c = (div_cnt_q == CNT_W'(CLK_DIV - 1));

    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard_c = 1'b0;
        end else begin : g_guard
            assign in_guard_c = (32'(div_cnt_q) < 32'(GUARD));
        end
    endgenerate

    // Select the scanned nibble; a digit blanks if it and everything above it is zero.
    always_comb begin
        nib_c        = 4'h0;
        dp_sel_c     = 1'b0;
        blank_c      = 1'b0;
        zero_above_c = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above_c = zero_above_c & (digits[4*i +: 4] == 4'h0);
            if (IDX_W'(i) == scan_idx_q) begin
                nib_c    = digits[4*i +: 4];
                dp_sel_c = dp_in[i];
                blank_c  = lz_en && (i != 0) && zero_above_c;
            end
        end
    end

    hex_to_seg7 u_dec (
        .nib_i   (nib_c),
        .seg_c_o (glyph_n_c)
    );

    always_comb begin
        div_cnt_d  = div_cnt_q;
        scan_idx_d = scan_idx_q;
        if (en) begin
            if (tick_c) begin
                div_cnt_d  = '0;
                scan_idx_d = (scan_idx_q == IDX_W'(N_DIGITS - 1)) ? '0
                                                                   : scan_idx_q + IDX_W'(1);
            end else begin
                div_cnt_d = div_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (en) begin
            an_d  = in_guard_c ? '1 : N_DIGITS'(an_onehot_n(3'(scan_idx_q)));
            seg_d = blank_c ? SEG_OFF : glyph_n_c;
            dp_d  = ~dp_sel_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= '0;
            scan_idx_q <= '0;
            an_q       <= '1;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
        end else begin
            div_cnt_q  <= div_cnt_d;
            scan_idx_q <= scan_idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;
    assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver; two instances (4/4/1 and 3/2/0)
// are compared every clock against a time-based reference model.
module tb_seg_scan_driver;

    localparam int NA = 4, DA = 4, GA = 1;
    localparam int NB = 3, DB = 2, GB = 0;

    localparam logic [6:0] GLY [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_en = 1'b0;
    logic        en = 1'b0;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a;
    logic [2:0] an_b;
    logic [1:0] idx_a, idx_b;

    seg_scan_driver #(.N_DIGITS(NA), .CLK_DIV(DA), .GUARD(GA)) dut_a (
        .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in), .lz_en(lz_en), .en(en),
        .seg(seg_a), .dp(dp_a), .an(an_a), .scan_idx(idx_a)
    );

    seg_scan_driver #(.N_DIGITS(NB), .CLK_DIV(DB), .GUARD(GB)) dut_b (
        .clk(clk), .rst(rst), .digits(digits[11:0]), .dp_in(dp_in[2:0]), .lz_en(lz_en), .en(en),
        .seg(seg_b), .dp(dp_b), .an(an_b), .scan_idx(idx_b)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Enabled-clock counts since reset; slot and position follow by division.
    int kA = 0, kB = 0;
    logic [3:0] exp_an_a;
    logic [2:0] exp_an_b;
    logic [6:0] exp_seg_a, exp_seg_b;
    logic       exp_dp_a, exp_dp_b;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [31:0] dig, input int idx, input bit lz);
        logic [31:0] upper;
        upper = dig >> (4 * idx);
        if (lz && idx > 0 && upper == 0) return 7'h7F;
        return ~GLY[upper[3:0]];
    endfunction

    function automatic logic [7:0] ref_an(input int n, input int idx, input int pos, input int guard);
        logic [7:0] all;
        all = 8'((1 << n) - 1);
        if (pos < guard) return all;
        return all & ~(8'd1 << idx);
    endfunction

    task automatic check_outputs();
        chk_eq("an_a",   32'(an_a),  32'(exp_an_a));
        chk_eq("seg_a",  32'(seg_a), 32'(exp_seg_a));
        chk_eq("dp_a",   32'(dp_a),  32'(exp_dp_a));
        chk_eq("idx_a",  32'(idx_a), 32'((kA / DA) % NA));
        chk_eq("an_b",   32'(an_b),  32'(exp_an_b));
        chk_eq("seg_b",  32'(seg_b), 32'(exp_seg_b));
        chk_eq("dp_b",   32'(dp_b),  32'(exp_dp_b));
        chk_eq("idx_b",  32'(idx_b), 32'((kB / DB) % NB));
    endtask

    // Apply inputs and predict what both instances register at the next rising edge.
    task automatic drive_and_predict(input logic [15:0] d, input logic [3:0] p,
                                     input bit lz, input bit e);
        int ia, pa, ib, pb;
        digits = d;
        dp_in  = p;
        lz_en  = lz;
        en     = e;
        ia = (kA / DA) % NA;
        pa = kA % DA;
        ib = (kB / DB) % NB;
        pb = kB % DB;
        if (e) begin
            exp_an_a  = 4'(ref_an(NA, ia, pa, GA));
            exp_seg_a = ref_seg({16'h0, d}, ia, lz);
            exp_dp_a  = ~p[ia];
            exp_an_b  = 3'(ref_an(NB, ib, pb, GB));
            exp_seg_b = ref_seg({20'h0, d[11:0]}, ib, lz);
            exp_dp_b  = ~p[ib];
            kA++;
            kB++;
        end else begin
            exp_an_a  = 4'hF;
            exp_seg_a = 7'h7F;
            exp_dp_a  = 1'b1;
            exp_an_b  = 3'h7;
            exp_seg_b = 7'h7F;
            exp_dp_b  = 1'b1;
        end
    endtask

    task automatic run(input int n, input logic [15:0] d, input logic [3:0] p,
                       input bit lz, input bit e);
        repeat (n) begin
            @(negedge clk);
            check_outputs();
            drive_and_predict(d, p, lz, e);
        end
    endtask

    // Reset asserted between edges must clear outputs with no clock edge.
    task automatic do_reset(input bit chk_first);
        @(negedge clk);
        if (chk_first) check_outputs();
        #2 rst = 1'b1;
        #1;
        chk_eq("rst_an_a",  32'(an_a),  32'hF);
        chk_eq("rst_seg_a", 32'(seg_a), 32'h7F);
        chk_eq("rst_dp_a",  32'(dp_a),  32'h1);
        chk_eq("rst_idx_a", 32'(idx_a), 32'h0);
        chk_eq("rst_an_b",  32'(an_b),  32'h7);
        chk_eq("rst_seg_b", 32'(seg_b), 32'h7F);
        chk_eq("rst_idx_b", 32'(idx_b), 32'h0);
        @(negedge clk);
        chk_eq("rst_hold_an_a", 32'(an_a), 32'hF);
        rst = 1'b0;
        kA = 0;
        kB = 0;
        drive_and_predict(16'h1234, 4'h0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [15:0] rd;
        int guard_cnt;

        do_reset(1'b0);
        run(40,  16'h1234, 4'b0100, 1'b0, 1'b1);
        run(32,  16'h00A0, 4'b0000, 1'b1, 1'b1);
        run(32,  16'h0000, 4'b0000, 1'b1, 1'b1);
        for (int v = 0; v < 16; v++) run(16, 16'(v), 4'b0000, 1'b0, 1'b1);

        // Drop en in the middle of digit slot 2.
        guard_cnt = 0;
        while (!(((kA / DA) % NA) == 2 && (kA % DA) == 2) && guard_cnt < 64) begin
            run(1, 16'h5678, 4'hF, 1'b0, 1'b1);
            guard_cnt++;
        end
        chk_eq("reach_slot2", 32'(guard_cnt < 64), 32'h1);
        run(10, 16'h5678, 4'hF, 1'b0, 1'b0);
        run(16, 16'h5678, 4'hF, 1'b0, 1'b1);

        run(5, 16'h9ABC, 4'h3, 1'b0, 1'b1);
        do_reset(1'b1);

        for (int c = 0; c < 1500; c++) begin
            rd = '0;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 1) == 1) rd[4*i +: 4] = 4'($urandom_range(0, 15));
            run(1, rd, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 9) != 0);
            if (c == 700) do_reset(1'b1);
        end

        @(negedge clk);
        check_outputs();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
